// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   pc_sel_t      : next-PC select encoding driven by the decoder
//   fetch_state_t : fetch FSM states
//   NOP_INSTR     : ADDI x0,x0,0, held in the instruction register after reset
// ----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JALR   = 2'b10,
      PC_HOLD   = 2'b11
   } pc_sel_t;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      ISSUE  = 2'b01,
      HALTED = 2'b10
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_mux.sv
// ----------------------------------------------------------------------------
// fetch_pc_mux
//   Combinational next-PC selection.
//   Ports:
//     pc            in   current program counter
//     pc_sel        in   next-PC select (pc_sel_t encoding)
//     branch_target in   pc+imm target for branches / JAL
//     jalr_target   in   ALU result for JALR (bit 0 cleared here)
//     next_pc       out  selected next program counter
//     misaligned    out  next_pc[1:0] != 0 (only with FETCH_MISALIGN_TRAP_EN)
//   Macro FETCH_MISALIGN_TRAP_EN: when undefined, next_pc is forced word-aligned
//   and no misaligned output exists.
// ----------------------------------------------------------------------------
import fetch_pkg::*;

module fetch_pc_mux #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic            misaligned,
`endif
   output logic [XLEN-1:0] next_pc
);

   always_comb begin
      next_pc = pc + XLEN'(4);
      unique case (pc_sel_t'(pc_sel))
         PC_PLUS4:  next_pc = pc + XLEN'(4);
         PC_BRANCH: next_pc = branch_target;
         // Masking keeps the whole operand in use while clearing bit 0.
         PC_JALR:   next_pc = jalr_target & ~XLEN'(1);
         PC_HOLD:   next_pc = pc;
         default:   next_pc = pc + XLEN'(4);
      endcase
`ifndef FETCH_MISALIGN_TRAP_EN
      next_pc[1:0] = 2'b00;
`endif
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned = |next_pc[1:0];
`endif

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: holds the PC, fetches words over a req/ready handshake,
//   presents the instruction plus decoder fields, and advances the PC on ack.
//   Ports:
//     clock, reset              single clock; asynchronous active-high reset
//     pc_sel, branch_target,
//     jalr_target, program_done decoder feedback, sampled only on instr_ack
//     instr_ack                 downstream consumed the current instruction
//     imem_req, imem_addr       fetch request / word address (= pc)
//     imem_rdata, imem_ready    memory response
//     instr, opcode, functs     latched instruction and decoder fields
//     instr_valid, pc, pc_plus4 instruction qualifiers and link value
//     halted, fetch_fault       sticky stop indications
//   Macro FETCH_MISALIGN_TRAP_EN: misaligned next_pc halts with fetch_fault=1;
//   otherwise next_pc is word-aligned and fetch_fault is tied low.
// ----------------------------------------------------------------------------
import fetch_pkg::*;

module instruction_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic            program_done,
   input  logic            instr_ack,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ready,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [9:0]      functs,
   output logic            instr_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            halted,
   output logic            fetch_fault
);

   fetch_state_t    state;
   logic [XLEN-1:0] next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   logic fault_q;
`endif

   fetch_pc_mux #(
      .XLEN (XLEN)
   ) u_pc_mux (
      .pc            (pc),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misaligned    (misaligned),
`endif
      .next_pc       (next_pc)
   );

   // imem_req is a registered output so it stays low during reset and rises
   // on the first edge after release, even though the state resets to FETCH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         halted      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            FETCH: begin
               // A response only counts while a request is actually outstanding.
               if (imem_req && imem_ready) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ISSUE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            ISSUE: begin
               if (instr_ack) begin
                  instr_valid <= 1'b0;
                  if (program_done) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end
`ifdef FETCH_MISALIGN_TRAP_EN
                  else if (misaligned) begin
                     // pc keeps the faulting instruction's address.
                     fault_q <= 1'b1;
                     halted  <= 1'b1;
                     state   <= HALTED;
                  end
`endif
                  else begin
                     pc       <= next_pc;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            HALTED: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
               state       <= HALTED;
            end
         endcase
      end
   end

   assign imem_addr = pc;
   assign pc_plus4  = pc + XLEN'(4);
   assign opcode    = instr[6:0];
   assign functs    = {instr[31:25], instr[14:12]};

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A memory responder pushes the
//   expected {instr, pc} into a scoreboard when it returns a word; scenario
//   tasks pop it once instr_valid is up and compare inline.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic [31:0] branch_target = '0;
   logic [31:0] jalr_target = '0;
   logic        program_done = 1'b0;
   logic        instr_ack = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ready = 1'b0;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [9:0]  functs;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic        fetch_fault;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] cur_pc;

   instruction_fetch #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .program_done  (program_done),
      .instr_ack     (instr_ack),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .instr         (instr),
      .opcode        (opcode),
      .functs        (functs),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .halted        (halted),
      .fetch_fault   (fetch_fault)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Memory responder: waits for a request, answers after 'delay' cycles.
   task automatic serve(input logic [31:0] rdata, input logic [31:0] exp_pc, input int delay);
      exp_t e;
      int   waited;
      e.instr = rdata;
      e.pc    = exp_pc;
      sb.push_back(e);
      waited = 0;
      while (!imem_req && waited < 50) begin
         tick();
         waited++;
      end
      if (!imem_req) begin
         n_tests++;
         n_fail++;
         $display("FAIL serve_timeout: imem_req=%0b after %0d cycles, required 1", imem_req, waited);
         return;
      end
      repeat (delay) tick();
      imem_ready = 1'b1;
      imem_rdata = rdata;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic ack(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] jt,
                      input logic done);
      pc_sel        = sel;
      branch_target = bt;
      jalr_target   = jt;
      program_done  = done;
      instr_ack     = 1'b1;
      tick();
      instr_ack     = 1'b0;
      program_done  = 1'b0;
      pc_sel        = 2'b00;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: req=%b valid=%b halted=%b fault=%b, required all 0",
                  imem_req, instr_valid, halted, fetch_fault);
      end
      n_tests++;
      if (pc !== 32'h0 || instr !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL reset_regs: pc=%h instr=%h, required pc=0 instr=00000013", pc, instr);
      end
      tick();
      tick();
      reset = 1'b0;
      n_tests++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_low: imem_req=%b, required 0", imem_req);
      end
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      serve(32'h0050_0093, 32'h0, 2);
      e = sb.pop_front();
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
         n_fail++;
         $display("FAIL basic_issue: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                  instr_valid, instr, pc, e.instr, e.pc);
      end
      n_tests++;
      if (opcode !== 7'b0010011 || functs !== 10'h0) begin
         n_fail++;
         $display("FAIL basic_fields: opcode=%b functs=%h, required 0010011 and 0", opcode, functs);
      end
      ack(2'b00, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_next: req=%b addr=%h valid=%b, required req=1 addr=4 valid=0",
                  imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      serve(32'h00B5_0463, 32'h4, 1);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc) begin
         n_fail++;
         $display("FAIL br_first: instr=%h pc=%h, required %h %h", instr, pc, e.instr, e.pc);
      end
      ack(2'b01, 32'h10, 32'h0, 1'b0);
      serve(32'h0020_8663, 32'h10, 0);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc || pc_plus4 !== 32'h14) begin
         n_fail++;
         $display("FAIL br_issue: instr=%h pc=%h pc_plus4=%h, required %h %h 00000014",
                  instr, pc, pc_plus4, e.instr, e.pc);
      end
      // A response strobe while in ISSUE must not disturb the held instruction.
      imem_ready = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      imem_ready = 1'b0;
      n_tests++;
      if (instr !== 32'h0020_8663 || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL br_ready_ignored: instr=%h valid=%b, required 00208663 valid=1",
                  instr, instr_valid);
      end
      ack(2'b01, 32'h40, 32'h0, 1'b0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_fail++;
         $display("FAIL br_target: req=%b addr=%h, required req=1 addr=40", imem_req, imem_addr);
      end
      // Ack while in FETCH must be ignored.
      ack(2'b01, 32'h100, 32'h0, 1'b0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_fail++;
         $display("FAIL ack_ignored: req=%b addr=%h, required req=1 addr=40", imem_req, imem_addr);
      end
   endtask

   task automatic test_jalr();
      exp_t e;
      serve(32'h0002_80E7, 32'h40, 1);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc) begin
         n_fail++;
         $display("FAIL jalr_issue: instr=%h pc=%h, required %h %h", instr, pc, e.instr, e.pc);
      end
      ack(2'b10, 32'h0, 32'h23, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (fetch_fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40) begin
            n_fail++;
            $display("FAIL jalr_trap: fault=%b halted=%b req=%b pc=%h, required 1 1 0 00000040",
                     fetch_fault, halted, imem_req, pc);
         end
         tick();
      end
      apply_reset();
      cur_pc = 32'h0;
`else
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL jalr_align: req=%b addr=%h fault=%b, required req=1 addr=20 fault=0",
                  imem_req, imem_addr, fetch_fault);
      end
      cur_pc = 32'h20;
`endif
   endtask

   task automatic test_wrap_hold();
      exp_t e;
      serve(32'h0000_0013, cur_pc, 0);
      e = sb.pop_front();
      ack(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
      serve(32'h0010_0113, 32'hFFFF_FFFC, 1);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc || pc_plus4 !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_issue: instr=%h pc=%h pc_plus4=%h, required %h %h 00000000",
                  instr, pc, pc_plus4, e.instr, e.pc);
      end
      ack(2'b00, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_next: req=%b addr=%h fault=%b, required req=1 addr=0 fault=0",
                  imem_req, imem_addr, fetch_fault);
      end
      serve(32'h0000_0033, 32'h0, 0);
      e = sb.pop_front();
      ack(2'b11, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL hold_refetch: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
      serve(32'h4000_0033, 32'h0, 0);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc || functs !== 10'h100 || opcode !== 7'h33) begin
         n_fail++;
         $display("FAIL hold_issue: instr=%h pc=%h functs=%h opcode=%h, required %h %h 100 33",
                  instr, pc, functs, opcode, e.instr, e.pc);
      end
      ack(2'b00, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (imem_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL hold_advance: addr=%h, required 00000004", imem_addr);
      end
   endtask

   task automatic test_halt();
      exp_t e;
      int   bad;
      serve(32'h0000_0073, 32'h4, 0);
      e = sb.pop_front();
      n_tests++;
      if (instr !== e.instr || pc !== e.pc) begin
         n_fail++;
         $display("FAIL halt_issue: instr=%h pc=%h, required %h %h", instr, pc, e.instr, e.pc);
      end
      ack(2'b00, 32'h0, 32'h0, 1'b1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            bad++;
            if (bad < 4)
               $display("FAIL halt_cycle%0d: halted=%b valid=%b req=%b, required 1 0 0",
                        i, halted, instr_valid, imem_req);
         end
         imem_ready = i[0];
         imem_rdata = 32'hAAAA_AAAA;
         instr_ack  = ~i[0];
         tick();
      end
      imem_ready = 1'b0;
      instr_ack  = 1'b0;
      n_tests++;
      if (pc !== 32'h4 || instr !== 32'h0000_0073) begin
         n_fail++;
         $display("FAIL halt_state: pc=%h instr=%h, required 00000004 00000073", pc, instr);
      end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      apply_reset();
      serve(32'h0000_0013, 32'h0, 0);
      e = sb.pop_front();
      ack(2'b01, 32'h80, 32'h0, 1'b0);
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
         n_fail++;
         $display("FAIL abort_wait: req=%b addr=%h, required req=1 addr=80", imem_req, imem_addr);
      end
      #3 reset = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || pc !== 32'h0 ||
          instr !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL abort_reset: req=%b valid=%b halted=%b pc=%h instr=%h, required 0 0 0 0 13",
                  imem_req, instr_valid, halted, pc, instr);
      end
      tick();
      reset = 1'b0;
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_restart: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
      serve(32'h00C0_0193, 32'h0, 0);
      e = sb.pop_front();
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
         n_fail++;
         $display("FAIL abort_refetch: valid=%b instr=%h pc=%h, required 1 %h %h",
                  instr_valid, instr, pc, e.instr, e.pc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch();
      test_jalr();
      test_wrap_hold();
      test_halt();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
